// File: rtl/memstage_pkg.sv
// Shared types for the load/store queue memory stage.
// MEMSTAGE_SIGNEXT_EN adds a per-entry sign-extend flag to lsq_entry_t.
package memstage_pkg;
  localparam int MAX_DW = 64;
  localparam int MAX_AW = 64;
  localparam int MAX_TW = 16;

  typedef enum logic [1:0] {OP_PASS = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2} op_e;
  typedef enum logic [1:0] {ST_FREE, ST_ISSUE, ST_RESP, ST_DONE} entry_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef struct packed {
    op_e               op;
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] data;
    size_e             size;
`ifdef MEMSTAGE_SIGNEXT_EN
    logic              sgn;
`endif
    logic [MAX_TW-1:0] tag;
    entry_state_e      state;
  } lsq_entry_t;

  function automatic int ptr_inc(input int p, input int depth);
    return (p + 1 == depth) ? 0 : p + 1;
  endfunction
endpackage

// File: rtl/mod_load_align.sv
// Load return aligner: shifts the addressed bytes to lane 0, then zero/sign extends.
module mod_load_align #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] data,
  input  logic [2:0]    off,
  input  logic [1:0]    size,
  input  logic          sgn,
  output logic [DW-1:0] result
);
  logic [DW-1:0] shifted, keep;
  logic          msb;
  int            nbits;

  always_comb begin
    shifted = data >> {off, 3'b000};
    nbits   = 8 << size;
    if (nbits > DW) nbits = DW;
    keep    = (nbits >= DW) ? '1 : ((DW'(1) << nbits) - DW'(1));
    msb     = |(shifted & (DW'(1) << (nbits - 1)));
    result  = (shifted & keep) | ({DW{sgn & msb}} & ~keep);
  end
endmodule

// File: rtl/mod_memstage_lsq.sv
// In-order load/store queue between decode and execute, DEPTH outstanding ops.
// MEMSTAGE_SIGNEXT_EN enables sign extension of loads flagged in_signed.
module mod_memstage_lsq
  import memstage_pkg::*;
#(
  parameter int DW    = 64,
  parameter int AW    = 64,
  parameter int TW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_wdata,
  input  logic [1:0]             in_size,
  input  logic                   in_signed,
  input  logic [TW-1:0]          in_tag,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [AW-1:0]          mem_req_addr,
  output logic                   mem_req_we,
  output logic [DW-1:0]          mem_req_wdata,
  output logic [1:0]             mem_req_size,
  input  logic                   mem_resp_valid,
  input  logic [DW-1:0]          mem_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [TW-1:0]          out_tag,
  output logic                   out_is_store,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   protocol_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] OFF_MASK = 3'(DW/8 - 1);

  lsq_entry_t    ent [DEPTH];
  logic [PW-1:0] alloc_ptr, issue_ptr, resp_ptr, retire_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] iss_idx, resp_idx, scan;
  logic          iss_hit, resp_hit, resp_sgn;
  logic          do_alloc, do_issue, do_resp, do_retire;
  logic [DW-1:0] aligned;
  op_e           in_op_e;

  // Entries are allocated in ring order, so the first ISSUE/RESP slot found
  // scanning forward from the pointer is the oldest one; PASS slots are skipped.
  always_comb begin
    iss_hit  = 1'b0;
    iss_idx  = issue_ptr;
    resp_hit = 1'b0;
    resp_idx = resp_ptr;
    scan     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan = issue_ptr + PW'(k);
      if (!iss_hit && ent[scan].state == ST_ISSUE) begin
        iss_hit = 1'b1;
        iss_idx = scan;
      end
      scan = resp_ptr + PW'(k);
      if (!resp_hit && ent[scan].state == ST_RESP) begin
        resp_hit = 1'b1;
        resp_idx = scan;
      end
    end
  end

  assign in_op_e   = (in_op == 2'd3) ? OP_PASS : op_e'(in_op);
  assign in_ready  = reset && (count != CW'(DEPTH));
  assign do_alloc  = in_valid && in_ready;
  assign do_issue  = iss_hit && mem_req_ready;
  assign do_resp   = mem_resp_valid && resp_hit;
  assign do_retire = out_valid && out_ready;

  assign mem_req_valid = iss_hit;
  assign mem_req_addr  = ent[iss_idx].addr[AW-1:0];
  assign mem_req_we    = iss_hit && (ent[iss_idx].op == OP_STORE);
  assign mem_req_wdata = ent[iss_idx].data[DW-1:0];
  assign mem_req_size  = ent[iss_idx].size;

  assign out_valid    = (ent[retire_ptr].state == ST_DONE);
  assign out_is_store = out_valid && (ent[retire_ptr].op == OP_STORE);
  assign out_data     = (ent[retire_ptr].op == OP_STORE) ? '0 : ent[retire_ptr].data[DW-1:0];
  assign out_tag      = ent[retire_ptr].tag[TW-1:0];
  assign occupancy    = count;

`ifdef MEMSTAGE_SIGNEXT_EN
  assign resp_sgn = ent[resp_idx].sgn;
`else
  logic unused_signed;
  assign unused_signed = in_signed;
  assign resp_sgn      = 1'b0;
`endif

  mod_load_align #(.DW(DW)) u_align (
    .data   (mem_resp_data),
    .off    (ent[resp_idx].addr[2:0] & OFF_MASK),
    .size   (ent[resp_idx].size),
    .sgn    (resp_sgn),
    .result (aligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      alloc_ptr    <= '0;
      issue_ptr    <= '0;
      resp_ptr     <= '0;
      retire_ptr   <= '0;
      count        <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (do_alloc) begin
        ent[alloc_ptr].op    <= in_op_e;
        ent[alloc_ptr].addr  <= MAX_AW'(in_addr);
        ent[alloc_ptr].data  <= MAX_DW'(in_wdata);
        ent[alloc_ptr].size  <= size_e'(in_size);
        ent[alloc_ptr].tag   <= MAX_TW'(in_tag);
        ent[alloc_ptr].state <= (in_op_e == OP_PASS) ? ST_DONE : ST_ISSUE;
`ifdef MEMSTAGE_SIGNEXT_EN
        ent[alloc_ptr].sgn   <= in_signed;
`endif
        alloc_ptr <= PW'(ptr_inc(int'(alloc_ptr), DEPTH));
      end
      if (do_issue) begin
        ent[iss_idx].state <= ST_RESP;
        issue_ptr          <= PW'(ptr_inc(int'(iss_idx), DEPTH));
      end
      if (do_resp) begin
        ent[resp_idx].state <= ST_DONE;
        if (ent[resp_idx].op == OP_LOAD) ent[resp_idx].data <= MAX_DW'(aligned);
        resp_ptr <= PW'(ptr_inc(int'(resp_idx), DEPTH));
      end
      if (mem_resp_valid && !resp_hit) protocol_err <= 1'b1;
      if (do_retire) begin
        ent[retire_ptr].state <= ST_FREE;
        retire_ptr            <= PW'(ptr_inc(int'(retire_ptr), DEPTH));
      end
      count <= count + CW'(do_alloc) - CW'(do_retire);
    end
  end
endmodule
